// File: rtl/tt_alu_pkg.sv
// Shared types and constants for the nibble-wide immediate ALU tile.
package tt_alu_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_OPERAND = 2'd1,
    ST_READ    = 2'd2,
    ST_EXEC    = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADDI = 4'd1,
    OP_SUBI = 4'd2,
    OP_ANDI = 4'd3,
    OP_ORI  = 4'd4,
    OP_XORI = 4'd5,
    OP_LDI  = 4'd6
  } opcode_e;

  localparam logic [3:0] BUSREQ_FETCH   = 4'b0000;
  localparam logic [3:0] BUSREQ_OPERAND = 4'b0011;
  localparam logic [3:0] BUSREQ_READ    = 4'b0001;
  localparam logic [3:0] BUSREQ_EXEC    = 4'b0100;

  // Opcodes 1..6 start an instruction; NOP and 7..15 leave the FSM in FETCH.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd6);
  endfunction

  // Bus-request code presented while the FSM sits in a given state.
  function automatic logic [3:0] busreq_code(input state_e st);
    logic [3:0] code;
    case (st)
      ST_FETCH:   code = BUSREQ_FETCH;
      ST_OPERAND: code = BUSREQ_OPERAND;
      ST_READ:    code = BUSREQ_READ;
      ST_EXEC:    code = BUSREQ_EXEC;
      default:    code = BUSREQ_FETCH;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/tt_alu_core.sv
// Combinational ALU: applies the latched opcode to register value and immediate.
module tt_alu_core
  import tt_alu_pkg::*;
(
  input  logic [DATA_W-1:0] opcode_i,
  input  logic [DATA_W-1:0] rv_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o
);

  logic [DATA_W:0] sum_s;
  logic [DATA_W:0] diff_s;

  // Widen by one bit so the top bit of the sum is the carry and of the difference is the borrow.
  always_comb begin
    sum_s  = {1'b0, rv_i} + {1'b0, imm_i};
    diff_s = {1'b0, rv_i} - {1'b0, imm_i};
    result_o = 4'd0;
    carry_o  = 1'b0;
    case (opcode_i)
      OP_ADDI: begin
        result_o = sum_s[DATA_W-1:0];
        carry_o  = sum_s[DATA_W];
      end
      OP_SUBI: begin
        result_o = diff_s[DATA_W-1:0];
        carry_o  = diff_s[DATA_W];
      end
      OP_ANDI: result_o = rv_i & imm_i;
      OP_ORI:  result_o = rv_i | imm_i;
      OP_XORI: result_o = rv_i ^ imm_i;
      OP_LDI:  result_o = imm_i;
      default: begin
        result_o = 4'd0;
        carry_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/tt_um_warriorjacq9_alu.sv
// TinyTapeout tile: four-state fetch/operand/read/exec immediate ALU.
module tt_um_warriorjacq9_alu
  import tt_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] opcode_q, opcode_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] rv_q, rv_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              carry_q, carry_d;

  logic [DATA_W-1:0] alu_result_s;
  logic              alu_carry_s;
  logic              unused_s;

  // Upper half of the bidirectional input carries nothing for this tile.
  assign unused_s = &{1'b0, uio_in[7:4]};

  tt_alu_core u_core (
    .opcode_i (opcode_q),
    .rv_i     (rv_q),
    .imm_i    (imm_q),
    .result_o (alu_result_s),
    .carry_o  (alu_carry_s)
  );

  // Next-state and field capture; everything holds while ena is low.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    imm_d    = imm_q;
    idx_d    = idx_q;
    rv_d     = rv_q;
    result_d = result_q;
    carry_d  = carry_q;
    if (ena) begin
      case (state_q)
        ST_FETCH: begin
          opcode_d = ui_in[3:0];
          imm_d    = ui_in[7:4];
          if (is_alu_op(ui_in[3:0])) begin
            state_d = ST_OPERAND;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_OPERAND: begin
          idx_d   = ui_in[7:4];
          state_d = ST_READ;
        end
        ST_READ: begin
          rv_d    = uio_in[3:0];
          state_d = ST_EXEC;
        end
        ST_EXEC: begin
          result_d = alu_result_s;
          carry_d  = alu_carry_s;
          state_d  = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and field registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      opcode_q <= 4'd0;
      imm_q    <= 4'd0;
      idx_q    <= 4'd0;
      rv_q     <= 4'd0;
      result_q <= 4'd0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      imm_q    <= imm_d;
      idx_q    <= idx_d;
      rv_q     <= rv_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  // Outputs come straight from registers or a decode of the state register.
  always_comb begin
    uo_out  = {idx_q, busreq_code(state_q)};
    uio_out = {3'b000, carry_q, result_q};
    if (state_q == ST_READ) begin
      uio_oe = 8'h00;
    end else begin
      uio_oe = 8'h1F;
    end
  end

endmodule

// File: tb/tb_tt_um_warriorjacq9_alu.sv
// Scoreboard bench for the immediate ALU tile.
module tb_tt_um_warriorjacq9_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];
  logic [4:0] last_exp = 5'd0;

  always #5 clk = ~clk;

  tt_um_warriorjacq9_alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Reference: {carry, result} from integer arithmetic.
  function automatic logic [4:0] model(input logic [3:0] op, input logic [3:0] rv, input logic [3:0] imm);
    int t;
    logic [4:0] r;
    r = 5'd0;
    case (op)
      4'd1: begin t = int'(rv) + int'(imm); r = {(t >= 16), 4'(t)}; end
      4'd2: begin t = int'(rv) - int'(imm); r = {(t < 0), 4'(t)}; end
      4'd3: r = {1'b0, rv & imm};
      4'd4: r = {1'b0, rv | imm};
      4'd5: r = {1'b0, rv ^ imm};
      4'd6: r = {1'b0, imm};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  task automatic pop_check(input string name);
    logic [4:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got uio_out=%h", name, uio_out);
    end else begin
      e = exp_q.pop_front();
      if (uio_out !== {3'b000, e}) begin
        n_err++;
        $display("FAIL %s: uio_out got %h expected %h", name, uio_out, {3'b000, e});
      end
      last_exp = e;
    end
  endtask

  task automatic wait_fetch();
    int k = 0;
    while (uo_out[3:0] !== 4'h0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (uo_out[3:0] !== 4'h0) begin
      n_err++;
      $display("FAIL wait_fetch: busreq got %h expected 0 within 10 cycles", uo_out[3:0]);
    end
  endtask

  task automatic run_instr(input string name, input logic [3:0] op, input logic [3:0] imm,
                           input logic [3:0] idx, input logic [3:0] rv);
    wait_fetch();
    ui_in = {imm, op};
    exp_q.push_back(model(op, rv, imm));
    @(negedge clk);
    n_cmp++;
    if (uo_out[3:0] !== 4'b0011) begin n_err++; $display("FAIL %s operand: busreq got %h expected 3", name, uo_out[3:0]); end
    ui_in = {idx, 4'h0};
    @(negedge clk);
    n_cmp++;
    if (uo_out !== {idx, 4'b0001} || uio_oe !== 8'h00) begin
      n_err++;
      $display("FAIL %s read: uo_out=%h uio_oe=%h expected uo_out=%h uio_oe=00", name, uo_out, uio_oe, {idx, 4'b0001});
    end
    uio_in = {4'h0, rv};
    @(negedge clk);
    n_cmp++;
    if (uo_out[3:0] !== 4'b0100 || uio_oe !== 8'h1F || uio_out !== {3'b000, last_exp}) begin
      n_err++;
      $display("FAIL %s exec: busreq=%h oe=%h uio_out=%h expected 4/1f/%h", name, uo_out[3:0], uio_oe, uio_out, {3'b000, last_exp});
    end
    ui_in = 8'h00;
    @(negedge clk);
    n_cmp++;
    if (uo_out[3:0] !== 4'b0000) begin n_err++; $display("FAIL %s fetch: busreq got %h expected 0", name, uo_out[3:0]); end
    pop_check(name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    #1;
    n_cmp++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h1F) begin
      n_err++;
      $display("FAIL reset: uo_out=%h uio_out=%h uio_oe=%h expected 00/00/1f", uo_out, uio_out, uio_oe);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_exp = 5'd0;
  endtask

  task automatic test_addi();
    run_instr("addi", 4'd1, 4'd3, 4'd1, 4'd4);
    run_instr("addi_overflow", 4'd1, 4'hF, 4'd2, 4'd1);
  endtask

  task automatic test_subi();
    run_instr("subi_borrow", 4'd2, 4'd1, 4'd3, 4'd0);
    run_instr("subi_plain", 4'd2, 4'd3, 4'd4, 4'd9);
  endtask

  task automatic test_logic();
    run_instr("andi", 4'd3, 4'd6, 4'd5, 4'hC);
    run_instr("ori", 4'd4, 4'd9, 4'd6, 4'h6);
    run_instr("xori", 4'd5, 4'hA, 4'd7, 4'hF);
    run_instr("ldi", 4'd6, 4'hD, 4'd8, 4'h2);
  endtask

  task automatic test_nop();
    logic [7:0] pats [2];
    pats[0] = 8'h00;
    pats[1] = 8'h5F;
    wait_fetch();
    for (int p = 0; p < 2; p++) begin
      ui_in = pats[p];
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        n_cmp++;
        if (uo_out[3:0] !== 4'h0 || uio_out !== {3'b000, last_exp}) begin
          n_err++;
          $display("FAIL nop_%h: busreq=%h uio_out=%h expected 0/%h", pats[p], uo_out[3:0], uio_out, {3'b000, last_exp});
        end
      end
    end
    ui_in = 8'h00;
  endtask

  task automatic test_ena_hold();
    wait_fetch();
    ui_in = 8'h54;
    exp_q.push_back(model(4'd4, 4'hA, 4'd5));
    @(negedge clk);
    ui_in = 8'h70;
    @(negedge clk);
    ena = 1'b0;
    uio_in = 8'h02;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (uo_out !== 8'h71 || uio_oe !== 8'h00) begin
        n_err++;
        $display("FAIL ena_hold: uo_out=%h uio_oe=%h expected 71/00", uo_out, uio_oe);
      end
    end
    uio_in = 8'h0A;
    ena = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (uo_out[3:0] !== 4'b0100) begin n_err++; $display("FAIL ena_resume: busreq got %h expected 4", uo_out[3:0]); end
    ui_in = 8'h00;
    @(negedge clk);
    pop_check("ena_result");
  endtask

  task automatic test_back_to_back();
    logic [3:0] codes [4];
    codes[0] = 4'b0011; codes[1] = 4'b0001; codes[2] = 4'b0100; codes[3] = 4'b0000;
    wait_fetch();
    ui_in = 8'h21;
    uio_in = 8'h03;
    exp_q.push_back(model(4'd1, 4'd3, 4'd2));
    exp_q.push_back(model(4'd1, 4'd9, 4'd2));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (uo_out[3:0] !== codes[i % 4]) begin
        n_err++;
        $display("FAIL b2b step %0d: busreq got %h expected %h", i, uo_out[3:0], codes[i % 4]);
      end
      if (i == 1) uio_in = 8'h03;
      if (i == 5) uio_in = 8'h09;
      if (i == 7) ui_in = 8'h00;
      if (i % 4 == 3) pop_check("b2b_result");
    end
  endtask

  task automatic test_mid_reset();
    wait_fetch();
    ui_in = 8'h31;
    @(negedge clk);
    ui_in = 8'h90;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h1F) begin
      n_err++;
      $display("FAIL mid_reset: uo_out=%h uio_out=%h uio_oe=%h expected 00/00/1f", uo_out, uio_out, uio_oe);
    end
    ui_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    last_exp = 5'd0;
    @(negedge clk);
    n_cmp++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      n_err++;
      $display("FAIL post_reset: uo_out=%h uio_out=%h expected 00/00", uo_out, uio_out);
    end
    run_instr("post_reset_addi", 4'd1, 4'd5, 4'd2, 4'd6);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_subi();
    test_logic();
    test_nop();
    test_ena_hold();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
